xge_rx_pkt_fifo: RTL and testbench
==================================

XGE_RX_PKT_FIFO -- requirements
Module: xge_rx_pkt_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 9, log2 of buffer depth in 69-bit words (tdata+tuser+tlast).
REQ-002 sys_clk  in  1  single clock for all logic; rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_tdata  in  64  RX beat data from the MAC AXI4-S RX port.
REQ-005 in_tuser  in  4  [2:0] valid bytes in last beat (0 means 8), [3] packet error; sampled only with in_tlast.
REQ-006 in_tlast  in  1  last beat of packet.
REQ-007 in_tvalid  in  1  beat valid.
REQ-008 in_tready  out  1  tied to 1 after reset; the block never back-pressures the MAC.
REQ-009 out_tdata  out  64  buffered beat data.
REQ-010 out_tuser  out  4  buffered tuser; bit[3] always 0 on output.
REQ-011 out_tlast  out  1  last beat of packet.
REQ-012 out_tvalid  out  1  output beat valid.
REQ-013 out_tready  in  1  downstream accept.
REQ-014 drop_err_count  out  16  packets dropped due to tuser[3] on tlast.
REQ-015 drop_ovf_count  out  16  packets dropped due to buffer overflow.

Function
REQ-016 Store-and-forward: no beat of a packet is presented on the output until its tlast beat has been written without error or overflow (committed).
REQ-017 Pointers: wr_ptr (speculative write), commit_ptr (end of last committed packet), rd_ptr (read); all DEPTH_LOG2 bits, wrap modulo 2^DEPTH_LOG2.
REQ-018 Full = (wr_ptr+1 == rd_ptr); usable capacity 2^DEPTH_LOG2-1 words.
REQ-019 Ingress FSM states ACCEPT and DROP; reset state ACCEPT.
REQ-020 ACCEPT, beat accepted, not full, in_tlast=0: write word, wr_ptr+1.
REQ-021 ACCEPT, beat with in_tlast=1, in_tuser[3]=0, not full: write word, commit_ptr <= wr_ptr+1, wr_ptr+1.
REQ-022 ACCEPT, beat with in_tlast=1, in_tuser[3]=1: no write, wr_ptr <= commit_ptr, drop_err_count+1; remain ACCEPT.
REQ-023 ACCEPT, beat while full, in_tlast=0: no write, wr_ptr <= commit_ptr, drop_ovf_count+1, go DROP.
REQ-024 ACCEPT, beat while full, in_tlast=1: no write, wr_ptr <= commit_ptr, drop_ovf_count+1, remain ACCEPT (overflow takes precedence over error; only one counter increments).
REQ-025 DROP: discard all beats; on in_tlast beat return to ACCEPT; no counter change.
REQ-026 Packets larger than capacity always overflow and are dropped; the FIFO never deadlocks.
REQ-027 Counters saturate at 16'hFFFF.
REQ-028 Egress: data available when rd_ptr != commit_ptr; buffer read is 1-cycle synchronous RAM feeding a registered output stage (one-entry skid permitted).
REQ-029 First beat of a packet appears on out_tvalid no later than 3 cycles after its commit when output is idle.
REQ-030 AXI rule: once out_tvalid=1, out_tdata/out_tuser/out_tlast stay stable until out_tready=1; rd_ptr advances only on consumption.
REQ-031 With out_tready held 1, egress sustains one beat per cycle across packet boundaries.
REQ-032 Simultaneous write/commit and read in one cycle are both performed; full uses rd_ptr before that cycle's increment.

Reset
REQ-033 On reset=1 at a clock edge: all pointers 0, FSM ACCEPT, out_tvalid 0, out_tdata/out_tuser/out_tlast 0, counters 0, in_tready 1; any partial or buffered packet is discarded.
REQ-034 Reset asserted mid-packet: remaining beats of that packet after release are written as a new packet starting at the next beat (upstream restarts on packet boundary).

Verification
REQ-035 Three 8-beat good packets, out_tready=1 -> 24 beats out in order, tlast on beats 8/16/24, tuser[2:0] preserved, counters 0.
REQ-036 Packet with tlast tuser=4'b1000 between two good packets -> only good packets out, drop_err_count=1.
REQ-037 DEPTH_LOG2=4, out_tready=0, send 10-beat then 10-beat packet -> first committed, second dropped, drop_ovf_count=1; release tready -> exactly 10 beats out.
REQ-038 DEPTH_LOG2=4, 20-beat packet -> dropped, drop_ovf_count=1, next 4-beat packet delivered intact.
REQ-039 Random out_tready toggling during 100 random-length packets -> output stream equals good input packets, data stable while out_tvalid=1 and out_tready=0.
REQ-040 reset pulsed during a packet in flight with buffered data -> out_tvalid=0 next cycle, counters 0, subsequent packets delivered normally.

Source files
------------

// File: rtl/xge_rx_pkt_fifo.sv
// Store-and-forward RX packet buffer: commits a packet only on a clean tlast, drops error/overflow packets.
// Commit-to-out_tvalid is 2 cycles; the ingress side never stalls, and egress holds its data stable while out_tready is low.
module xge_rx_pkt_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [63:0] in_tdata,
    input  logic [3:0]  in_tuser,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [63:0] out_tdata,
    output logic [3:0]  out_tuser,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [15:0] drop_err_count,
    output logic [15:0] drop_ovf_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    typedef struct packed {
        logic [63:0] tdata;
        logic [3:0]  tuser;
        logic        tlast;
    } word_t;

    typedef enum logic {ACCEPT, DROP} state_t;

    word_t  mem [DEPTH];

    state_t state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   commit_ptr_q, commit_ptr_d;
    ptr_t   rd_ptr_q;
    ptr_t   fetch_ptr_q;
    ptr_t   wr_ptr_inc;
    logic   full;
    logic   wr_en;
    logic   err_inc;
    logic   ovf_inc;
    word_t  wr_word;
    logic [15:0] err_cnt_q;
    logic [15:0] ovf_cnt_q;

    word_t  ram_dat_q;
    logic   ram_vld_q;
    word_t  out_dat_q, out_dat_d;
    logic   out_vld_q, out_vld_d;
    word_t  sk_dat_q, sk_dat_d;
    logic   sk_vld_q, sk_vld_d;
    logic   pop;
    logic   rd_issue;

    assign in_tready  = 1'b1;
    assign wr_ptr_inc = wr_ptr_q + ptr_t'(1);
    assign full       = (wr_ptr_inc == rd_ptr_q);

    // tuser only carries meaning on the tlast beat; bit 3 is never stored since errored packets are not committed.
    assign wr_word.tdata = in_tdata;
    assign wr_word.tuser = {1'b0, in_tlast ? in_tuser[2:0] : 3'b000};
    assign wr_word.tlast = in_tlast;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        err_inc      = 1'b0;
        ovf_inc      = 1'b0;
        if (in_tvalid) begin
            case (state_q)
                ACCEPT: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        ovf_inc  = 1'b1;
                        if (!in_tlast) begin
                            state_d = DROP;
                        end
                    end else if (in_tlast && in_tuser[3]) begin
                        wr_ptr_d = commit_ptr_q;
                        err_inc  = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_inc;
                        if (in_tlast) begin
                            commit_ptr_d = wr_ptr_inc;
                        end
                    end
                end
                DROP: begin
                    if (in_tlast) begin
                        state_d = ACCEPT;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            if (err_inc && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (ovf_inc && ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end
    end

    assign drop_err_count = err_cnt_q;
    assign drop_ovf_count = ovf_cnt_q;

    // Output register plus one skid entry; a read is issued only if its data is sure to find a free slot.
    always_comb begin
        pop       = out_vld_q && out_tready;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        sk_vld_d  = sk_vld_q;
        sk_dat_d  = sk_dat_q;
        if (!out_vld_q || pop) begin
            if (sk_vld_q) begin
                out_vld_d = 1'b1;
                out_dat_d = sk_dat_q;
                sk_vld_d  = ram_vld_q;
                sk_dat_d  = ram_dat_q;
            end else begin
                out_vld_d = ram_vld_q;
                if (ram_vld_q) begin
                    out_dat_d = ram_dat_q;
                end
            end
        end else if (ram_vld_q) begin
            sk_vld_d = 1'b1;
            sk_dat_d = ram_dat_q;
        end
        rd_issue = (fetch_ptr_q != commit_ptr_q) && !(out_vld_d && sk_vld_d);
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_word;
        end
        if (rd_issue) begin
            ram_dat_q <= mem[fetch_ptr_q];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            ram_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            sk_vld_q    <= 1'b0;
            sk_dat_q    <= '0;
        end else begin
            fetch_ptr_q <= rd_issue ? fetch_ptr_q + ptr_t'(1) : fetch_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
            ram_vld_q   <= rd_issue;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            sk_vld_q    <= sk_vld_d;
            sk_dat_q    <= sk_dat_d;
        end
    end

    assign out_tvalid = out_vld_q;
    assign out_tdata  = out_dat_q.tdata;
    assign out_tuser  = out_dat_q.tuser;
    assign out_tlast  = out_dat_q.tlast;

endmodule

// File: tb/tb_xge_rx_pkt_fifo.sv
// Directed bench for xge_rx_pkt_fifo (DEPTH_LOG2=4, 15-word capacity) with an output scoreboard.
module tb_xge_rx_pkt_fifo;

    logic        sys_clk;
    logic        reset;
    logic [63:0] in_tdata;
    logic [3:0]  in_tuser;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [63:0] out_tdata;
    logic [3:0]  out_tuser;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic [15:0] drop_err_count;
    logic [15:0] drop_ovf_count;

    xge_rx_pkt_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .in_tdata       (in_tdata),
        .in_tuser       (in_tuser),
        .in_tlast       (in_tlast),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .out_tdata      (out_tdata),
        .out_tuser      (out_tuser),
        .out_tlast      (out_tlast),
        .out_tvalid     (out_tvalid),
        .out_tready     (out_tready),
        .drop_err_count (drop_err_count),
        .drop_ovf_count (drop_ovf_count)
    );

    int          total = 0;
    int          bad = 0;
    int          rx_count = 0;
    bit          rnd_rdy = 0;
    bit          prev_stall = 0;
    logic [68:0] prev_word;
    logic [68:0] exp_q[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: a beat seen valid+ready here is accepted at the next rising edge.
    always @(negedge sys_clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                assert (out_tvalid === 1'b1 && {out_tdata, out_tuser, out_tlast} === prev_word) else begin
                    bad++;
                    $error("FAIL stable: obs=%b/%h exp=1/%h", out_tvalid, {out_tdata, out_tuser, out_tlast}, prev_word);
                end
            end
            if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_beat: obs=%h exp=none", {out_tdata, out_tuser, out_tlast});
                end
                if (exp_q.size() != 0) begin
                    logic [68:0] e;
                    e = exp_q.pop_front();
                    total++;
                    assert ({out_tdata, out_tuser, out_tlast} === e) else begin
                        bad++;
                        $error("FAIL beat: obs=%h exp=%h", {out_tdata, out_tuser, out_tlast}, e);
                    end
                end
                rx_count++;
            end
            prev_stall = (out_tvalid === 1'b1) && (out_tready !== 1'b1);
            prev_word  = {out_tdata, out_tuser, out_tlast};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [3:0] ulast, input bit good, input logic [15:0] tag);
        for (int i = 0; i < len; i++) begin
            logic last;
            last      = (i == len - 1);
            in_tvalid = 1'b1;
            in_tdata  = {tag, 16'hA5A5, 32'(i)};
            in_tlast  = last;
            in_tuser  = last ? ulast : 4'h0;
            if (good) begin
                exp_q.push_back({in_tdata, last ? {1'b0, ulast[2:0]} : 4'h0, last});
            end
            if (rnd_rdy) begin
                out_tready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 4'h0;
    endtask

    task automatic drain(input string tag, input int budget, output int ncyc);
        ncyc = 0;
        while (exp_q.size() != 0 && ncyc < budget) begin
            if (rnd_rdy) begin
                out_tready = 1'($urandom_range(0, 1));
            end
            tick();
            ncyc++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int lat;
        int rx0;
        int nbad;
        int room_fail;

        reset      = 1'b1;
        in_tdata   = '0;
        in_tuser   = '0;
        in_tlast   = 1'b0;
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        repeat (3) tick();

        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tdata", out_tdata, 64'd0);
        chk("rst_out_tuser", 64'(out_tuser), 64'd0);
        chk("rst_out_tlast", 64'(out_tlast), 64'd0);
        chk("rst_in_tready", 64'(in_tready), 64'd1);
        chk("rst_err_cnt", 64'(drop_err_count), 64'd0);
        chk("rst_ovf_cnt", 64'(drop_ovf_count), 64'd0);
        reset = 1'b0;
        tick();

        // Three back-to-back 8-beat packets streamed with out_tready=1.
        out_tready = 1'b1;
        send_pkt(8, 4'b0011, 1, 16'h0100);
        send_pkt(8, 4'b0000, 1, 16'h0101);
        send_pkt(8, 4'b0101, 1, 16'h0102);
        drain("drain_3x8", 100, cyc);
        chk("stream_no_bubbles", 64'(cyc <= 10), 64'd1);
        chk("rx_3x8", 64'(rx_count), 64'd24);
        chk("3x8_err_cnt", 64'(drop_err_count), 64'd0);
        chk("3x8_ovf_cnt", 64'(drop_ovf_count), 64'd0);

        // Commit-to-valid latency from an idle output.
        out_tready = 1'b0;
        send_pkt(2, 4'b0100, 1, 16'h0200);
        lat = 0;
        while (out_tvalid !== 1'b1 && lat < 4) begin
            tick();
            lat++;
        end
        chk("commit_to_valid_le3", 64'(lat <= 3), 64'd1);
        repeat (3) tick();
        out_tready = 1'b1;
        drain("drain_lat", 50, cyc);

        // Errored packet between two good ones.
        send_pkt(8, 4'b0010, 1, 16'h0300);
        send_pkt(5, 4'b1000, 0, 16'h0301);
        send_pkt(3, 4'b0111, 1, 16'h0302);
        drain("drain_err", 100, cyc);
        chk("err_cnt_1", 64'(drop_err_count), 64'd1);
        chk("err_ovf_cnt_0", 64'(drop_ovf_count), 64'd0);

        // Two 10-beat packets with output blocked: second overflows.
        out_tready = 1'b0;
        rx0 = rx_count;
        send_pkt(10, 4'b0001, 1, 16'h0400);
        send_pkt(10, 4'b0001, 0, 16'h0401);
        repeat (3) tick();
        chk("ovf_cnt_1", 64'(drop_ovf_count), 64'd1);
        chk("blocked_no_rx", 64'(rx_count - rx0), 64'd0);
        out_tready = 1'b1;
        drain("drain_ovf", 100, cyc);
        repeat (5) tick();
        chk("ovf_rx_10", 64'(rx_count - rx0), 64'd10);

        // Oversized packet always overflows; next packet intact.
        send_pkt(20, 4'b0000, 0, 16'h0500);
        send_pkt(4, 4'b0110, 1, 16'h0501);
        drain("drain_big", 100, cyc);
        chk("big_ovf_cnt_2", 64'(drop_ovf_count), 64'd2);
        chk("big_err_cnt_1", 64'(drop_err_count), 64'd1);

        // Exact-capacity packet, then overflow on an errored tlast and on a multi-beat packet.
        out_tready = 1'b0;
        rx0 = rx_count;
        send_pkt(15, 4'b0011, 1, 16'h0600);
        send_pkt(1, 4'b1000, 0, 16'h0601);
        chk("ovf_precedence_ovf", 64'(drop_ovf_count), 64'd3);
        chk("ovf_precedence_err", 64'(drop_err_count), 64'd1);
        send_pkt(2, 4'b0001, 0, 16'h0602);
        chk("full_ovf_cnt_4", 64'(drop_ovf_count), 64'd4);
        out_tready = 1'b1;
        drain("drain_full", 100, cyc);
        repeat (3) tick();
        chk("full_rx_15", 64'(rx_count - rx0), 64'd15);
        send_pkt(3, 4'b0110, 1, 16'h0603);
        drain("drain_after_full", 50, cyc);

        // Random lengths with random out_tready; stay within capacity so only error drops happen.
        rnd_rdy = 1;
        nbad = 0;
        room_fail = 0;
        for (int p = 0; p < 100; p++) begin
            int len;
            bit isbad;
            len   = $urandom_range(1, 12);
            isbad = ($urandom_range(0, 7) == 0);
            cyc = 0;
            while (exp_q.size() + len > 15 && cyc < 2000) begin
                out_tready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            if (cyc >= 2000) begin
                room_fail++;
            end
            if (isbad) begin
                nbad++;
            end
            send_pkt(len, {isbad, 3'($urandom_range(0, 7))}, !isbad, 16'h1000 + 16'(p));
        end
        chk("rand_room_timeouts", 64'(room_fail), 64'd0);
        drain("drain_rand", 3000, cyc);
        rnd_rdy = 0;
        out_tready = 1'b1;
        chk("rand_err_cnt", 64'(drop_err_count), 64'(1 + nbad));
        chk("rand_ovf_cnt", 64'(drop_ovf_count), 64'd4);

        // Reset with a buffered packet and a partial packet in flight.
        out_tready = 1'b0;
        send_pkt(5, 4'b0010, 1, 16'h0E00);
        for (int i = 0; i < 3; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = {16'h0E01, 16'hDEAD, 32'(i)};
            in_tlast  = 1'b0;
            in_tuser  = 4'h0;
            tick();
        end
        in_tvalid = 1'b0;
        chk("prereset_vld", 64'(out_tvalid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("midrst_err_cnt", 64'(drop_err_count), 64'd0);
        chk("midrst_ovf_cnt", 64'(drop_ovf_count), 64'd0);
        send_pkt(4, 4'b0011, 1, 16'h0E02);
        send_pkt(6, 4'b0000, 1, 16'h0E03);
        out_tready = 1'b1;
        rx0 = rx_count;
        drain("drain_after_rst", 100, cyc);
        repeat (20) tick();
        chk("after_rst_rx_10", 64'(rx_count - rx0), 64'd10);
        chk("after_rst_err_cnt", 64'(drop_err_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
